// File: rtl/control_contador_bcd_pkg.sv
// Shared types for the gated BCD counter sequencer.
// State encoding and gate-timer width helper.
package control_contador_bcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_READ,
    S_DONE
  } state_t;

  function automatic int tmr_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/control_contador_bcd_if.sv
// Controller <-> counter / readout bundle.
// master = sequencer, slave = counter plus readout side.
interface control_contador_bcd_if #(
  parameter int N = 3
);
  localparam int SW = $clog2(N);

  logic          start;
  logic [3:0]    digit;
  logic          cnt_rst;
  logic          cnt_en;
  logic [SW-1:0] cnt_sel;
  logic          busy;
  logic [N*4-1:0] result;
  logic          result_valid;

  modport master (
    input  start,
    input  digit,
    output cnt_rst,
    output cnt_en,
    output cnt_sel,
    output busy,
    output result,
    output result_valid
  );

  modport slave (
    output start,
    output digit,
    input  cnt_rst,
    input  cnt_en,
    input  cnt_sel,
    input  busy,
    input  result,
    input  result_valid
  );

endinterface

// File: rtl/control_contador_bcd_sincronizador_flanco.sv
// Two-flop synchronizer plus rising-edge detector.
// Emits a single-cycle pulse per synchronized 0->1 edge.
module sincronizador_flanco (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/control_contador_bcd.sv
// Gated event-count sequencer for an N-digit cascaded BCD counter.
// Define CONTROL_BCD_CONTINUOUS_EN for back-to-back measurements.
module control_contador_bcd
  import control_contador_bcd_pkg::*;
#(
  parameter int N           = 3,
  parameter int GATE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  control_contador_bcd_if.master bus
);

  localparam int SW = $clog2(N);
  localparam int TW = tmr_width(GATE_CYCLES);
  localparam logic [TW-1:0] LAST_T = TW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] LAST_K = SW'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic [TW-1:0]  r_tmr;
  logic [SW-1:0]  r_k;
  logic [N*4-1:0] r_shadow;
  logic [N*4-1:0] r_result;
  logic [N*4-1:0] w_shadow_nx;
  logic           w_pulse;
  logic           w_last_k;

  sincronizador_flanco u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (evt),
    .o_pulse (w_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign w_last_k = (r_k == LAST_K);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_GATE;
      S_GATE:   if (r_tmr == LAST_T) w_next = S_SETTLE;
      S_SETTLE: w_next = S_READ;
      S_READ:   if (w_last_k) w_next = S_DONE;
`ifdef CONTROL_BCD_CONTINUOUS_EN
      S_DONE:   w_next = bus.start ? S_CLEAR : S_IDLE;
`else
      S_DONE:   w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shadow_nx = r_shadow;
    for (int i = 0; i < N; i++) begin
      if (r_k == SW'(i)) w_shadow_nx[i*4 +: 4] = bus.digit;
    end
  end

  // result is loaded with the final digit on entry to DONE,
  // so it is already valid during the result_valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr    <= '0;
      r_k      <= '0;
      r_shadow <= '0;
      r_result <= '0;
    end else begin
      if (r_state == S_CLEAR)     r_tmr <= '0;
      else if (r_state == S_GATE) r_tmr <= r_tmr + 1'b1;

      if (r_state == S_READ && !w_last_k) r_k <= r_k + 1'b1;
      else                                r_k <= '0;

      if (r_state == S_CLEAR)     r_shadow <= '0;
      else if (r_state == S_READ) r_shadow <= w_shadow_nx;

      if (r_state == S_READ && w_last_k) r_result <= w_shadow_nx;
    end
  end

  always_comb begin
    bus.busy         = (r_state != S_IDLE);
    bus.cnt_rst      = rst | (r_state == S_CLEAR);
    bus.cnt_en       = ~rst & (r_state == S_GATE) & w_pulse;
    bus.cnt_sel      = (r_state == S_READ) ? r_k : '0;
    bus.result_valid = ~rst & (r_state == S_DONE);
    bus.result       = r_result;
  end

endmodule

// File: tb/tb_control_contador_bcd.sv
// Scoreboarded bench: behavioural BCD counter, directed event trains.
// Build with CONTROL_BCD_CONTINUOUS_EN to add the back-to-back case.
module tb_control_contador_bcd;

  localparam int N = 3;
  localparam int G = 4000;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic evt = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  logic [3:0] cnt [N];
  bit         carry;

  control_contador_bcd_if #(.N(N)) bus ();

  control_contador_bcd #(
    .N           (N),
    .GATE_CYCLES (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .evt (evt),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference cascaded BCD counter
  always @(posedge clk) begin
    if (bus.cnt_rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= 4'h0;
    end else if (bus.cnt_en) begin
      carry = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (carry) begin
          if (cnt[i] == 4'd9) begin
            cnt[i] <= 4'h0;
          end else begin
            cnt[i] <= cnt[i] + 4'h1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  assign bus.digit =
    (int'(bus.cnt_sel) < N) ? cnt[bus.cnt_sel] : 4'h0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", cyc, -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", bus.result, e.val);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle(input int t, input int exp_val);
    int n;
    n = 0;
    while (bus.busy && n < G + 50) begin
      tick();
      n++;
    end
    chk("busy_fall", cyc, t + G + 6);
    chk("result_hold", bus.result, exp_val);
    repeat (4) tick();
  endtask

  task automatic pulses(input int np, input int hi, input int lo);
    repeat (np) begin
      evt = 1'b1;
      repeat (hi) tick();
      evt = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic measure(input int np, input int hi,
                         input int lo, input int exp_val);
    int t;
    bus.start = 1'b1;
    t = cyc + 1;
    q.push_back('{exp_val, t + G + 5});
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    pulses(np, hi, lo);
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    wait_idle(t, exp_val);
  endtask

  initial begin
    int t;
    bus.start = 1'b0;

    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt_rst", bus.cnt_rst, 1);
    chk("rst_cnt_en", bus.cnt_en, 0);
    chk("rst_cnt_sel", bus.cnt_sel, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.result_valid, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_cnt_rst", bus.cnt_rst, 0);
    repeat (3) tick();

    measure(0, 3, 3, 'h000);
    measure(37, 3, 3, 'h037);

    // abort at gate cycle 50
    bus.start = 1'b1;
    t = cyc + 1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    pulses(5, 3, 3);
    while (cyc < t + 49) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_cnt_rst", bus.cnt_rst, 1);
    chk("abort_cnt_en", bus.cnt_en, 0);
    rst = 1'b0;
    tick();
    chk("abort_cnt_clear", {cnt[2], cnt[1], cnt[0]}, 0);
    chk("abort_idle", bus.busy, 0);
    repeat (4) tick();

    measure(5, 3, 3, 'h005);

    // edges landing in the first and last gate cycles
    bus.start = 1'b1;
    evt = 1'b1;
    t = cyc + 1;
    q.push_back('{'h002, t + G + 5});
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    evt = 1'b0;
    while (cyc < t + G - 2) tick();
    evt = 1'b1;
    repeat (3) tick();
    evt = 1'b0;
    wait_idle(t, 'h002);

    // edges landing in CLEAR and SETTLE
    evt = 1'b1;
    t = cyc + 2;
    q.push_back('{'h000, t + G + 5});
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    evt = 1'b0;
    while (cyc < t + G - 1) tick();
    evt = 1'b1;
    repeat (3) tick();
    evt = 1'b0;
    wait_idle(t, 'h000);

    measure(1003, 2, 1, 'h003);

`ifdef CONTROL_BCD_CONTINUOUS_EN
    begin
      int tw;
      int vals [3];
      vals[0] = 3;
      vals[1] = 7;
      vals[2] = 2;
      bus.start = 1'b1;
      t = cyc + 1;
      tick();
      for (int w = 0; w < 3; w++) begin
        tw = t + w * (G + 6);
        q.push_back('{vals[w], tw + G + 5});
        while (cyc < tw) tick();
        if (w > 0) chk("cont_busy", bus.busy, 1);
        while (cyc < tw + 5) tick();
        pulses(vals[w], 2, 2);
      end
      bus.start = 1'b0;
      wait_idle(t + 2 * (G + 6), 'h002);
    end
`endif

    repeat (10) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
